// File: rtl/dout_trace_capture_if.sv
// Bundle of the capture, read and status signals of the dout trace FIFO.
// The host side owns the controls; the capture block owns the results.
interface dout_trace_capture_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 8
);
    logic              cap_en;
    logic              cap_mode;
    logic [DATA_W-1:0] dout_in;
    logic              rd_en;
    logic              clr_ovf;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output cap_en, cap_mode, dout_in, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );

    modport slave (
        input  cap_en, cap_mode, dout_in, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow, drop_cnt
    );
endinterface

// File: rtl/dout_trace_capture.sv
// Samples the processor dout bus into a FIFO, either every enabled cycle or only
// on change, with a registered read port and sticky/saturating overflow accounting.
module dout_trace_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DROP_W = 8
) (
    input logic                clk,
    input logic                sys_rst,
    dout_trace_capture_if.slave bus
);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              empty_reg;
    logic              full_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] last_reg;
    logic              have_last_reg;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_cnt_reg;

    logic cap_req;
    logic rd_acc;
    logic wr_acc;
    logic drop;

    // In on-change mode the very first sample after (re)enable is always taken.
    always_comb begin
        cap_req = bus.cap_en & (~bus.cap_mode | ~have_last_reg | (bus.dout_in != last_reg));
        rd_acc  = bus.rd_en & ~empty_reg;
        wr_acc  = cap_req & (~full_reg | rd_acc);
        drop    = cap_req & ~wr_acc;
    end

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && sys_rst) begin
            mem[wptr_reg] <= bus.dout_in;
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            last_reg      <= '0;
            have_last_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == CNT_FULL);
            rd_valid_reg <= rd_acc;
            if (rd_acc) begin
                rd_data_reg <= mem[rptr_reg];
                rptr_reg    <= rptr_reg + PTR_ONE;
            end
            if (wr_acc) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            // A dropped sample must not become the on-change reference value.
            if (!bus.cap_en) begin
                have_last_reg <= 1'b0;
            end else if (wr_acc) begin
                last_reg      <= bus.dout_in;
                have_last_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (bus.clr_ovf) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != '1) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
            end
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.empty    = empty_reg;
    assign bus.full     = full_reg;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
    assign bus.drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_dout_trace_capture.sv
// Bench for dout_trace_capture: a queue of expected samples is filled as captures
// are driven and emptied by a monitor whenever the DUT presents rd_valid.
module tb_dout_trace_capture;
    logic clk = 1'b0;
    logic sys_rst = 1'b0;

    dout_trace_capture_if #(.DATA_W(16), .ADDR_W(4), .DROP_W(8)) bus ();

    dout_trace_capture #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .DROP_W(8)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_popped = 16'h0000;
    int          m_count = 0;
    logic [15:0] m_last = 16'h0000;
    bit          m_have = 1'b0;

    // Scoreboard: every rd_valid must match the oldest outstanding capture.
    always @(negedge clk) begin
        if (sys_rst && bus.rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: got rd_data=%04h with nothing outstanding", bus.rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data_order: got %04h expected %04h", bus.rd_data, e);
                end else begin
                    $display("read %04h ok", bus.rd_data);
                end
                last_popped = bus.rd_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // One clock: drive inputs, predict what gets written, advance past the edge.
    task automatic step(input logic ce, input logic cm, input logic [15:0] d,
                        input logic re, input logic cl);
        bit rd_acc, cap_req, wr_acc;
        bus.cap_en   = ce;
        bus.cap_mode = cm;
        bus.dout_in  = d;
        bus.rd_en    = re;
        bus.clr_ovf  = cl;
        rd_acc  = re && (m_count != 0);
        cap_req = ce && (!cm || !m_have || (d != m_last));
        wr_acc  = cap_req && ((m_count != 16) || rd_acc);
        if (wr_acc) begin
            exp_q.push_back(d);
            m_last = d;
            m_have = 1'b1;
        end
        if (!ce) m_have = 1'b0;
        m_count = m_count + int'(wr_acc) - int'(rd_acc);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("check %s = %0h ok", name, got);
        end
    endtask

    task automatic test_reset();
        bus.cap_en = 0; bus.cap_mode = 0; bus.dout_in = 0; bus.rd_en = 0; bus.clr_ovf = 0;
        sys_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_rd_data",  32'(bus.rd_data), 32'h0);
        check_val("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_val("reset_empty",    32'(bus.empty), 32'h1);
        check_val("reset_full",     32'(bus.full), 32'h0);
        check_val("reset_count",    32'(bus.count), 32'h0);
        check_val("reset_overflow", 32'(bus.overflow), 32'h0);
        check_val("reset_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        sys_rst = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_every_cycle();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("every_count", 32'(bus.count), 32'd4);
        check_val("every_empty_before", 32'(bus.empty), 32'h0);
        drain(4);
        check_val("every_empty_after", 32'(bus.empty), 32'h1);
        check_val("every_outstanding", 32'(exp_q.size()), 32'd0);
        check_val("every_last_read", 32'(last_popped), 32'h0004);
    endtask

    task automatic test_on_change();
        logic [15:0] seq [6] = '{16'h00AA, 16'h00AA, 16'h00AA, 16'h0055, 16'h0055, 16'h00AA};
        foreach (seq[i]) step(1'b1, 1'b1, seq[i], 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0);
        check_val("change_count", 32'(bus.count), 32'd3);
        // Re-enable with the same value: must be captured again.
        step(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0);
        check_val("change_reenable_count", 32'(bus.count), 32'd4);
        drain(4);
        check_val("change_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0, 1'b0);
        check_val("ovf_full_at_16", 32'(bus.full), 32'h1);
        check_val("ovf_none_yet", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("ovf_full", 32'(bus.full), 32'h1);
        check_val("ovf_count", 32'(bus.count), 32'd16);
        check_val("ovf_flag", 32'(bus.overflow), 32'h1);
        check_val("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd3);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("ovf_clear_flag", 32'(bus.overflow), 32'h0);
        check_val("ovf_clear_drop", 32'(bus.drop_cnt), 32'h0);
    endtask

    task automatic test_full_rw();
        step(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("fullrw_count", 32'(bus.count), 32'd16);
        check_val("fullrw_full", 32'(bus.full), 32'h1);
        check_val("fullrw_overflow", 32'(bus.overflow), 32'h0);
        drain(16);
        check_val("fullrw_last", 32'(last_popped), 32'hBEEF);
        check_val("fullrw_empty", 32'(bus.empty), 32'h1);
        check_val("fullrw_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 254; i++) step(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b0, 1'b0);
        check_val("sat_drop_254", 32'(bus.drop_cnt), 32'hFE);
        step(1'b1, 1'b0, 16'h0500, 1'b0, 1'b0);
        check_val("sat_drop_255", 32'(bus.drop_cnt), 32'hFF);
        for (int i = 0; i < 45; i++) step(1'b1, 1'b0, 16'h0600 + 16'(i), 1'b0, 1'b0);
        check_val("sat_drop_300", 32'(bus.drop_cnt), 32'hFF);
        check_val("sat_overflow", 32'(bus.overflow), 32'h1);
        // Clear coinciding with a drop: the clear wins.
        step(1'b1, 1'b0, 16'h0700, 1'b0, 1'b1);
        check_val("sat_clr_wins_drop", 32'(bus.drop_cnt), 32'h0);
        check_val("sat_clr_wins_ovf", 32'(bus.overflow), 32'h0);
        drain(16);
        check_val("sat_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h1111 * 16'(i + 1), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h7777, 1'b1, 1'b0);
        #2;
        sys_rst = 1'b0;
        bus.cap_en = 0; bus.rd_en = 0; bus.clr_ovf = 0;
        exp_q.delete();
        m_count = 0;
        m_have  = 1'b0;
        #1;
        check_val("arst_rd_data",  32'(bus.rd_data), 32'h0);
        check_val("arst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_val("arst_count",    32'(bus.count), 32'h0);
        check_val("arst_empty",    32'(bus.empty), 32'h1);
        check_val("arst_full",     32'(bus.full), 32'h0);
        @(posedge clk);
        #1;
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
            check_val("arst_no_rd_valid", 32'(bus.rd_valid), 32'h0);
        end
        check_val("arst_empty_after", 32'(bus.empty), 32'h1);
    endtask

    initial begin
        test_reset();
        test_every_cycle();
        test_on_change();
        test_overflow();
        test_full_rw();
        test_saturate();
        test_async_reset();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
